samul_seq: RTL

Parametrised, sequential shift-add multiplier: the multi-cycle successor to the combinational 32-bit signed/magnitude multiplier. It processes one multiplier bit per clock with a W+1-bit carry/accumulator, selects signed (two's-complement) or unsigned operation per transaction, and uses valid/ready handshakes on both sides. It sits between an operand-issuing datapath stage and a result consumer that may stall.

---
 rtl/samul_pkg.sv | 18 +
 rtl/samul_cneg.sv | 13 +
 rtl/samul_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/samul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// The state enum and counter sizing live here so the top and bench agree.
package samul_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Counter must be able to hold WIDTH itself: 0..WIDTH-1 iterate, WIDTH finishes.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/samul_cneg.sv
// Conditional two's-complement negator.
// Used for operand magnitudes and to re-sign the final product.
module samul_cneg #(
  parameter int W = 32
) (
  input  logic         i_en,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);

  assign o_y = i_en ? (~i_x + W'(1)) : i_x;

endmodule

// File: rtl/samul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per clock,
// signed or unsigned per transaction, valid/ready on both sides.
module samul_seq
  import samul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = cnt_w(WIDTH);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH:0]     r_a;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_result;

  logic [WIDTH-1:0]   w_m_abs;
  logic [WIDTH-1:0]   w_q_abs;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_last;
  logic               w_neg_a;
  logic               w_neg_b;

  assign w_neg_a = signed_mode & a[WIDTH-1];
  assign w_neg_b = signed_mode & b[WIDTH-1];

  samul_cneg #(.W(WIDTH)) u_cneg_m (
    .i_en (w_neg_a),
    .i_x  (a),
    .o_y  (w_m_abs)
  );

  samul_cneg #(.W(WIDTH)) u_cneg_q (
    .i_en (w_neg_b),
    .i_x  (b),
    .o_y  (w_q_abs)
  );

  // A never exceeds WIDTH bits after a shift, so A+M fits in WIDTH+1.
  assign w_sum  = r_q[0] ? (r_a + {1'b0, r_m}) : r_a;
  assign w_last = (r_cnt == CW'(WIDTH));

  samul_cneg #(.W(2*WIDTH)) u_cneg_p (
    .i_en (r_neg),
    .i_x  ({r_a[WIDTH-1:0], r_q}),
    .o_y  (w_prod)
  );

  assign in_ready  = rst_n & (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = CALC;
      end
      CALC: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m      <= '0;
      r_q      <= '0;
      r_a      <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_m   <= w_m_abs;
            r_q   <= w_q_abs;
            r_neg <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_a   <= '0;
            r_cnt <= '0;
          end
        end
        CALC: begin
          if (w_last) begin
            r_result <= w_prod;
          end else begin
            r_a   <= {1'b0, w_sum[WIDTH:1]};
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule
